// File: rtl/picoblaze_irq_arbiter.sv
// picoblaze_irq_arbiter
// Shares the single KCPSM6 interrupt line and in_port between N_SRC event
// sources. Each source posts a one-cycle request with an 8-bit payload; the
// arbiter latches it as pending, grants one source at a time, raises
// interrupt, and after interrupt_ack exposes the source index (SRC_PORT) and
// payload (DATA_PORT). Reading DATA_PORT retires the grant.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin selection starting
// after the last granted source. Without it, the lowest pending index wins.
module picoblaze_irq_arbiter #(
    parameter int          N_SRC      = 4,
    parameter logic [7:0]  SRC_PORT   = 8'h00,
    parameter logic [7:0]  DATA_PORT  = 8'h03,
    parameter int          GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     req,
    input  logic [8*N_SRC-1:0]   req_data,
    input  logic [7:0]           ext_in_port,
    input  logic [7:0]           port_id,
    input  logic                 read_strobe,
    input  logic                 interrupt_ack,
    output logic                 interrupt,
    output logic [7:0]           in_port,
    output logic [N_SRC-1:0]     pending,
    output logic [N_SRC-1:0]     overflow,
    output logic                 busy
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, IRQ, SERVE, GAP} state_t;

    state_t             state_reg;
    logic               interrupt_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic [7:0]         grant_data_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [N_SRC-1:0]   pending_reg;
    logic [N_SRC-1:0]   overflow_reg;
    logic [7:0]         slot_data_reg [N_SRC];

    logic [7:0]         req_bytes [N_SRC];
    logic [N_SRC-1:0]   retire_hit;
    logic               retire;
    logic [IDX_W-1:0]   winner_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               winner_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   last_grant_reg;
    int                 rr_cand;
`endif

    // The ISR retires the current grant by reading the payload port
    assign retire = (state_reg == SERVE) && read_strobe && (port_id == DATA_PORT);

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign req_bytes[gi]  = req_data[8*gi +: 8];
            assign retire_hit[gi] = retire && (grant_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Request latch: a retire in the same cycle lets a fresh request take the slot
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg  <= '0;
            overflow_reg <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (req[i]) begin
                    if (!pending_reg[i] || retire_hit[i]) begin
                        pending_reg[i]   <= 1'b1;
                        slot_data_reg[i] <= req_bytes[i];
                    end else begin
                        overflow_reg[i]  <= 1'b1;
                    end
                end else if (retire_hit[i]) begin
                    pending_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Winner selection among pending sources
    always_comb begin
        winner_valid = |pending_reg;
        winner_idx   = '0;
        scan_idx     = '0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_cand = 0;
        // Scan from farthest to nearest so the first index after the last grant wins
        for (int k = N_SRC; k >= 1; k--) begin
            rr_cand  = (int'(last_grant_reg) + k) % N_SRC;
            scan_idx = IDX_W'(rr_cand);
            if (pending_reg[scan_idx]) begin
                winner_idx = scan_idx;
            end
        end
`else
        // Scan downwards so the lowest pending index wins
        for (int k = N_SRC - 1; k >= 0; k--) begin
            scan_idx = IDX_W'(k);
            if (pending_reg[scan_idx]) begin
                winner_idx = scan_idx;
            end
        end
`endif
    end

    // Grant FSM: IDLE -> IRQ -> SERVE -> GAP -> IDLE, interrupt registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            interrupt_reg  <= 1'b0;
            grant_idx_reg  <= '0;
            grant_data_reg <= '0;
            gap_cnt_reg    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_reg <= IDX_W'(N_SRC - 1);
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (winner_valid) begin
                        grant_idx_reg  <= winner_idx;
                        grant_data_reg <= slot_data_reg[winner_idx];
                        interrupt_reg  <= 1'b1;
                        state_reg      <= IRQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_reg <= winner_idx;
`endif
                    end
                end
                IRQ: begin
                    if (interrupt_ack) begin
                        interrupt_reg <= 1'b0;
                        state_reg     <= SERVE;
                    end
                end
                SERVE: begin
                    if (retire) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    interrupt_reg <= 1'b0;
                end
            endcase
        end
    end

    // Read-port mux; SRC_PORT reports 8'hFF whenever no grant is being served
    always_comb begin
        in_port = ext_in_port;
        if (port_id == SRC_PORT) begin
            in_port = (state_reg == SERVE) ? 8'(grant_idx_reg) : 8'hFF;
        end else if ((port_id == DATA_PORT) && (state_reg == SERVE)) begin
            in_port = grant_data_reg;
        end
    end

    assign interrupt = interrupt_reg;
    assign pending   = pending_reg;
    assign overflow  = overflow_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/picoblaze_irq_arbiter.md
Name: picoblaze_irq_arbiter

Overview:
- Shares the single KCPSM6 interrupt line and in_port between N_SRC event sources: start button, keyboard scan-code receiver, timers and similar.
- Each source posts a one-cycle request carrying an 8-bit payload. The arbiter latches it as pending, selects one winner and raises interrupt.
- After interrupt_ack, the arbiter presents source ID and payload on two input ports for the ISR to read.
- It sits between the event producers and the processor's interrupt/in_port pins, beside the output-port decode.

Parameters:
- N_SRC, 4, number of requesters; legal range 2..8.
- SRC_PORT, 8'h00, port_id that returns the granted source index.
- DATA_PORT, 8'h03, port_id that returns the granted payload. Reading it retires the grant.
- GAP_CYCLES, 2, minimum number of cycles interrupt stays low between two grants; legal range ≥1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_SRC  one-cycle request strobes, one per source.
- req_data  in  8*N_SRC  payloads; source i uses bits [8i+7:8i], sampled when req[i]=1.
- ext_in_port  in  8  default input data for all other port_ids.
- port_id  in  8  from kcpsm6.
- read_strobe  in  1  from kcpsm6.
- interrupt_ack  in  1  from kcpsm6.
- interrupt  out  1  to kcpsm6.
- in_port  out  8  to kcpsm6; combinational mux.
- pending  out  N_SRC  latched, not-yet-retired requests.
- overflow  out  N_SRC  sticky; a request arrived while that source was already pending.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on reset.
  - Reset values: interrupt=0, pending=0, overflow=0, busy=0, state=IDLE, grant_idx=0, grant_data=0, gap counter=0.
  - Reset asserted mid-operation aborts any grant the same cycle; in_port reverts to ext_in_port on the next cycle.
- Request latch, per source i, each cycle:
  - If req[i]=1 and pending[i]=0: set pending[i]=1 and capture req_data[i] into slot_data[i].
  - If req[i]=1 and pending[i]=1: keep slot_data[i] unchanged (the new payload is dropped) and set overflow[i]=1.
  - Exception: if pending[i] is being retired in the same cycle, the new request wins. pending[i] stays 1, the new data is captured and overflow is not set.
- States:
  - IDLE: interrupt=0. If pending≠0, the winner is the lowest set index. Latch grant_idx and grant_data<=slot_data[winner], then go to IRQ on the next cycle.
  - IRQ: interrupt=1. On interrupt_ack=1, go to SERVE and drop interrupt to 0 next cycle. The arbiter waits in IRQ indefinitely while the ISR has interrupts disabled. Other sources' requests keep being latched.
  - SERVE: interrupt=0. When read_strobe=1 and port_id==DATA_PORT, clear pending[grant_idx] and go to GAP.
  - GAP: interrupt=0. Count GAP_CYCLES, then return to IDLE.
- in_port mux (combinational, every state):
  - In SERVE with port_id==SRC_PORT: in_port = {zero-extended grant_idx}.
  - In SERVE with port_id==DATA_PORT: in_port = grant_data.
  - With port_id==SRC_PORT outside SERVE: in_port = 8'hFF (no grant).
  - Otherwise: in_port = ext_in_port.
- Reads of SRC_PORT have no side effect and may be repeated.
- Latency: a req on an idle arbiter gives pending on the next edge, then IDLE→IRQ on the following edge. interrupt is therefore high 2 cycles after the req edge.
- grant_data is frozen at grant time. A later req from the granted source during IRQ/SERVE sets overflow and does not alter the served payload.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined:
  - The IDLE winner is the first pending index strictly after the last granted index, wrapping modulo N_SRC.
  - The last-granted pointer resets to N_SRC-1, so index 0 wins first after reset.
- Undefined: fixed priority, lowest index wins.

Test Plan:
- Reset then idle: hold reset 3 cycles with req=0 → interrupt=0, busy=0, pending=0. port_id=8'h00 gives in_port=8'hFF. port_id=8'h05 with ext_in_port=8'h5A gives in_port=8'h5A.
- Single request: req[1] pulse with data 8'h1D → interrupt=1 two cycles later. After ack, SRC read=8'h01 and DATA read=8'h1D. pending[1] clears on that read. interrupt stays low ≥2 cycles.
- Simultaneous: req[0]=8'h02 and req[2]=8'h1B in the same cycle → grant 0 first, then source 2 after the gap.
  - Fixed priority: req[0] and req[3] re-posted after each retire → 0 always wins.
  - ARB_ROUND_ROBIN_EN: grants alternate 0,3,0,3.
- Overflow: req[2]=8'hAA, then req[2]=8'hBB before retire → payload read = 8'hAA, overflow[2]=1, sticky until reset.
- Retire collision: req[1]=8'h44 in the same cycle as DATA_PORT read of grant 1 → pending[1] stays 1, overflow[1]=0, next grant delivers 8'h44.
- Reset during SERVE: reset pulse after ack → interrupt=0, pending=0, in_port at DATA_PORT = ext_in_port on the next cycle.
